// File: rtl/base_pkg.sv
// Shared select helpers for the steering and arbitration cells.
// Vectors are carried at MAX_WAYS bits; callers zero-extend narrower selects.
package base_pkg;

    localparam int MAX_WAYS = 32;

    typedef logic [MAX_WAYS-1:0] sel_vec_t;

    // Isolates the lowest set bit: index 0 wins.
    function automatic sel_vec_t pri_onehot(input sel_vec_t v);
        return v & (~v + sel_vec_t'(1));
    endfunction

    function automatic logic is_onehot(input sel_vec_t v);
        return (v != '0) && ((v & (v - sel_vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/base_prisplit_slot.sv
// One-entry registered output slot: load to o_v in 1 cycle.
// Reports free when empty or draining, so a load and a drain may share a cycle.
module base_prisplit_slot #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [0:width-1] d,
    output logic             o_v,
    input  logic             o_r,
    output logic [0:width-1] o_d,
    output logic             free
);

    logic             full;
    logic [0:width-1] data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                data <= d;
            end else if (full && o_r) begin
                // Data is left in place on drain; consumers qualify with o_v.
                full <= 1'b0;
            end
        end
    end

    assign o_v  = full;
    assign o_d  = data;
    assign free = ~full | o_r;

endmodule

// File: rtl/base_prisplit.sv
// Steers each input beat to the lowest-index way in i_sel; 1-cycle latency to o_v.
// i_r follows the selected slot's free flag; a zero select is always accepted and dropped.
module base_prisplit
    import base_pkg::*;
#(
    parameter int ways  = 2,
    parameter int width = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [0:width-1]       i_d,
    input  logic [0:ways-1]        i_sel,
    output logic [0:ways-1]        o_v,
    input  logic [0:ways-1]        o_r,
    output logic [0:ways*width-1]  o_d,
    output logic                   o_err
);

    sel_vec_t        sel_vec;
    sel_vec_t        sel_oh;
    sel_vec_t        free_vec;
    logic [0:ways-1] free;
    logic [0:ways-1] load;
    logic            sel_zero;
    logic            xfer;
    logic            err_q;

    // Re-index the select into the package's little-endian vector form.
    always_comb begin
        sel_vec  = '0;
        free_vec = '0;
        for (int k = 0; k < ways; k++) begin
            sel_vec[k]  = i_sel[k];
            free_vec[k] = free[k];
        end
    end

    assign sel_oh   = pri_onehot(sel_vec);
    assign sel_zero = (sel_vec == '0);
    assign i_r      = sel_zero | (|(sel_oh & free_vec));
    assign xfer     = i_v & i_r;

    always_comb begin
        load = '0;
        for (int k = 0; k < ways; k++) begin
            load[k] = xfer & sel_oh[k];
        end
    end

    for (genvar k = 0; k < ways; k++) begin : g_slot
        base_prisplit_slot #(
            .width (width)
        ) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[k]),
            .d       (i_d),
            .o_v     (o_v[k]),
            .o_r     (o_r[k]),
            .o_d     (o_d[k*width +: width]),
            .free    (free[k])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= xfer & ~is_onehot(sel_vec);
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_base_prisplit.sv
// Scoreboard bench for base_prisplit with four 8-bit ways.
module tb_base_prisplit;

    localparam int WAYS  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  i_v;
    logic                  i_r;
    logic [0:WIDTH-1]      i_d;
    logic [0:WAYS-1]       i_sel;
    logic [0:WAYS-1]       o_v;
    logic [0:WAYS-1]       o_r;
    logic [0:WAYS*WIDTH-1] o_d;
    logic                  o_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q [WAYS][$];
    logic       hold   [WAYS];
    logic [7:0] hold_d [WAYS];
    logic       err_exp;

    base_prisplit #(
        .ways  (WAYS),
        .width (WIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_v     (i_v),
        .i_r     (i_r),
        .i_d     (i_d),
        .i_sel   (i_sel),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_d     (o_d),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:WAYS-1] way_sel(input int k);
        logic [0:WAYS-1] s;
        s    = '0;
        s[k] = 1'b1;
        return s;
    endfunction

    function automatic logic [7:0] slice(input logic [0:WAYS*WIDTH-1] v, input int k);
        return v[k*WIDTH +: WIDTH];
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [0:WAYS-1] sel, input logic [7:0] d, output int stalls);
        logic done;
        stalls = 0;
        i_v    = 1'b1;
        i_sel  = sel;
        i_d    = d;
        forever begin
            @(negedge clk);
            done = i_r;
            @(posedge clk);
            #1;
            if (done) break;
            stalls++;
            if (stalls > 50) begin
                check("send_timeout", 32'(stalls), 0);
                break;
            end
        end
    endtask

    task automatic idle();
        i_v   = 1'b0;
        i_sel = '0;
        i_d   = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: model occupancy is the queue depth; pop on drain, push on transfer.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        int         esel;
        int         n1;
        if (!reset_n) begin
            for (int k = 0; k < WAYS; k++) begin
                q[k].delete();
                hold[k] = 1'b0;
            end
            err_exp = 1'b0;
            check("rst_ov", 32'(o_v), 0);
        end else begin
            check("o_err", 32'(o_err), 32'(err_exp));
            for (int k = 0; k < WAYS; k++) begin
                check($sformatf("o_v%0d", k), 32'(o_v[k]), 32'(q[k].size() != 0));
                if (hold[k]) begin
                    check($sformatf("hold_v%0d", k), 32'(o_v[k]), 1);
                    check($sformatf("hold_d%0d", k), 32'(slice(o_d, k)), 32'(hold_d[k]));
                end
                hold[k]   = o_v[k] & ~o_r[k];
                hold_d[k] = slice(o_d, k);
                if (o_v[k] && o_r[k] && q[k].size() != 0) begin
                    exp_d = q[k].pop_front();
                    check($sformatf("data%0d", k), 32'(slice(o_d, k)), 32'(exp_d));
                end
            end
            err_exp = 1'b0;
            if (i_v) begin
                esel = 0;
                n1   = 0;
                for (int k = WAYS - 1; k >= 0; k--) begin
                    if (i_sel[k]) begin
                        esel = k;
                        n1++;
                    end
                end
                check("i_r", 32'(i_r), 32'((n1 == 0) || (q[esel].size() == 0)));
                if (i_r) begin
                    if (n1 != 0) q[esel].push_back(i_d);
                    err_exp = (n1 != 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int st;
        int st2;
        int total;

        // Reset state
        reset_n = 1'b0;
        o_r     = '1;
        idle();
        #3;
        check("rst_o_v", 32'(o_v), 0);
        check("rst_o_d", o_d, 0);
        check("rst_o_err", 32'(o_err), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_cycles(1);

        // First beat after reset release
        send(way_sel(2), 8'h5A, st);
        check("rel_stall", 32'(st), 0);
        check("rel_o_v", 32'(o_v), 32'(way_sel(2)));
        check("rel_o_d2", 32'(slice(o_d, 2)), 32'h5A);
        check("rel_o_err", 32'(o_err), 0);
        idle();
        wait_cycles(2);

        // Backpressure on way 1
        o_r[1] = 1'b0;
        fork
            begin
                send(way_sel(1), 8'h11, st);
                send(way_sel(1), 8'h22, st2);
                idle();
            end
            begin
                wait_cycles(4);
                check("bp_hold", 32'(slice(o_d, 1)), 32'h11);
                o_r[1] = 1'b1;
            end
        join
        check("bp_first_stall", 32'(st), 0);
        check("bp_second_stall", 32'(st2), 3);
        check("bp_next", 32'(slice(o_d, 1)), 32'h22);
        wait_cycles(2);

        // Full throughput on way 3
        total = 0;
        for (int i = 0; i < 16; i++) begin
            send(way_sel(3), 8'(i), st);
            total += st;
        end
        idle();
        check("thru_stalls", 32'(total), 0);
        wait_cycles(2);

        // Interleaved ways with way 0 stalled for 3 cycles
        o_r[0] = 1'b0;
        fork
            begin
                send(way_sel(0), 8'h30, st);
                check("ilv_w0a", 32'(st), 0);
                send(way_sel(1), 8'h31, st);
                check("ilv_w1", 32'(st), 0);
                send(way_sel(0), 8'h32, st);
                check("ilv_w0b", 32'(st), 1);
                send(way_sel(2), 8'h33, st);
                check("ilv_w2", 32'(st), 0);
                idle();
            end
            begin
                wait_cycles(3);
                o_r[0] = 1'b1;
            end
        join
        wait_cycles(3);

        // Multi-hot select goes to the lowest index and flags an error
        send(way_sel(1) | way_sel(2), 8'hA5, st);
        idle();
        check("multi_err", 32'(o_err), 1);
        check("multi_o_v", 32'(o_v), 32'(way_sel(1)));
        check("multi_o_d1", 32'(slice(o_d, 1)), 32'hA5);
        wait_cycles(1);
        check("multi_err_clr", 32'(o_err), 0);
        wait_cycles(2);

        // Zero-hot select is accepted and dropped
        send('0, 8'hC3, st);
        idle();
        check("zero_stall", 32'(st), 0);
        check("zero_err", 32'(o_err), 1);
        check("zero_o_v", 32'(o_v), 0);
        wait_cycles(1);
        check("zero_err_clr", 32'(o_err), 0);
        wait_cycles(1);

        // Async reset while ways 0 and 2 hold stalled beats
        o_r[0] = 1'b0;
        o_r[2] = 1'b0;
        send(way_sel(0), 8'h40, st);
        send(way_sel(2), 8'h42, st);
        idle();
        wait_cycles(2);
        check("pre_rst_o_v", 32'(o_v), 32'(way_sel(0) | way_sel(2)));
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_o_v", 32'(o_v), 0);
        check("mid_rst_o_d", o_d, 0);
        wait_cycles(2);
        @(negedge clk);
        #2 reset_n = 1'b1;
        o_r = '1;
        wait_cycles(4);
        check("post_rst_o_v", 32'(o_v), 0);

        total = 0;
        for (int k = 0; k < WAYS; k++) total += q[k].size();
        check("sb_empty", 32'(total), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
